data_mem_ctrl: RTL

//  Data-memory responder for the RV32I core: serves load/store requests issued by
//  the register-file / LSU side (store data from rs2, load data back to rd).

---
 rtl/dmem_pkg.sv | 73 +++++++
 rtl/dmem_sram.sv | 26 ++
 rtl/data_mem_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the RV32I data-memory controller.
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Stores accept only the signed encodings; loads also take BU/HU.
  function automatic logic size_bad(logic we, logic [2:0] size);
    logic bad;
    if (we)
      bad = !(size inside {SZ_B, SZ_H, SZ_W});
    else
      bad = !(size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU});
    return bad;
  endfunction

  function automatic logic misaligned(logic [2:0] size, logic [1:0] off);
    return (size[1:0] == 2'b01 && off[0]) ||
           (size[1:0] == 2'b10 && off != 2'b00);
  endfunction

  function automatic logic [3:0] byte_en(logic [2:0] size, logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(logic [2:0] size,
                                              logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_B:    d = {4{wdata[7:0]}};
      SZ_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_ext(logic [2:0] size,
                                           logic [1:0] off,
                                           logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = {{24{b[7]}}, b};
      SZ_H:    r = {{16{h[15]}}, h};
      SZ_BU:   r = {24'h0, b};
      SZ_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-organised SRAM, byte-lane write enables, registered read.
module dmem_sram #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents deliberately survive reset, so no reset here.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i])
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// RV32I data-memory responder: IDLE -> BUSY -> RESP, one response per request.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned H/W instead of aligning.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmem_state_e      state;
  logic             lat_we;
  logic             lat_err;
  logic [2:0]       lat_size;
  logic [1:0]       lat_off;
  logic [IDX_W-1:0] lat_idx;

  logic             accept;
  logic             mis;
  logic             err_now;
  logic [3:0]       wen;
  logic [IDX_W-1:0] idx;
  logic [31:0]      sram_rdata;
  logic             unused;

  assign unused    = ^req_addr[ADDR_W-1:IDX_W+2];
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[2 +: IDX_W];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = misaligned(req_size, req_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign err_now = size_bad(req_we, req_size) || mis;
  // Stores commit on the accepting edge.
  assign wen = (accept && req_we && !err_now)
             ? byte_en(req_size, req_addr[1:0]) : 4'b0000;

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk  (clk),
    .we   (wen),
    .waddr(idx),
    .wdata(store_lanes(req_size, req_wdata)),
    .re   (state == ST_BUSY),
    .raddr(lat_idx),
    .rdata(sram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_size  <= 3'b000;
      lat_off   <= 2'b00;
      lat_idx   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_we   <= req_we;
            lat_err  <= err_now;
            lat_size <= req_size;
            lat_off  <= req_addr[1:0];
            lat_idx  <= idx;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: state <= ST_RESP;
        ST_RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= lat_err;
          rsp_rdata <= (lat_err || lat_we) ? 32'h0
                     : load_ext(lat_size, lat_off, sram_rdata);
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
